dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the consumer end of the ALU-result address path.
- Accepts one load/store request at a time from the datapath: byte address = ALUresult, write data = rt, MemWrite/MemtoReg-derived strobes.
- Performs the access against an internal word array after a programmable latency.
- Returns exactly one response per request over a valid/ready handshake; the zero-extended read word goes to the writeback mux.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥4.
- RD_LAT, 2, cycles from request acceptance to rsp_valid; integer ≥1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data.
- req_we  input  1  store (MemWrite).
- req_re  input  1  load (MemtoReg path).
- req_be  input  4  byte enables for stores; bit i covers wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load data; 0 for stores and errored requests.
- rsp_err  output  1  request was out of range (or misaligned, see feature).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, latency counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array contents are not cleared by reset.
- Accept: req_valid & req_ready on a rising edge. Address, wdata, be, we and re are captured into request registers at that edge.
- Request with req_we=0 and req_re=0 (nop) is still accepted and still answered: rsp_rdata=0, rsp_err=0.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2].
- Out of range: any of req_addr[31:log2(DEPTH_WORDS)+2] nonzero. Then rsp_err=1, no array write, rsp_rdata=0.
- States:
  - IDLE: req_ready=1. On accept → WAIT, counter=RD_LAT-1.
  - WAIT: req_ready=0. Decrement counter each cycle. When counter=0:
    - perform the access;
    - load rsp_rdata/rsp_err;
    - → RESP with rsp_valid=1 on the next cycle.
    - With RD_LAT=1, WAIT lasts exactly one cycle.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready. Then → IDLE: rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency: rsp_valid rises RD_LAT+1 edges after the accepting edge. The earliest next accept is on the edge after the response handshake.
- Store: array word updated only on bytes with req_be[i]=1, at the WAIT→RESP edge. req_be=0 writes nothing and is not an error.
- Load: rsp_rdata = full 32-bit word at the index, read at the WAIT→RESP edge.
- we=1 and re=1 together: write first, then read. rsp_rdata returns the post-write word (merged bytes).
- Back-to-back store then load to the same address: the load sees the stored data. No stale read is permitted.
- rsp_ready held high: RESP lasts one cycle.
- rsp_ready held low: RESP persists indefinitely; req_ready stays 0.
- Inputs while req_ready=0 are ignored. Request registers do not change.
- Reset mid-operation (WAIT or RESP):
  - state returns to IDLE and the pending response is dropped.
  - A store reset while in WAIT before its commit edge is not written.
  - A store already committed stays committed.
- No X on outputs after reset, regardless of inputs.

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined:
  - A request with req_addr[1:0]≠0 is misaligned: rsp_err=1, no write, rsp_rdata=0. Same latency and handshake as a normal request.
  - Applies to loads, stores and nops alike.
- Undefined: req_addr[1:0] is ignored; the access uses the word index only.

Test Plan:
- Reset then idle, RD_LAT=2 → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Deassert rst → no response appears.
- Store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load 0x10 (rsp_ready=1) →
  - store response rsp_err=0, rdata=0;
  - load rsp_rdata=0xDEADBEEF;
  - rsp_valid rises 3 edges after each accept.
- Store 0x10 be=4'b0101 wdata=0x11223344 over 0xDEADBEEF, then load 0x10 → rsp_rdata=0xDE22BE44.
- Load addr=0x400 with DEPTH_WORDS=256 → rsp_err=1, rsp_rdata=0. A subsequent load of word 0 is unchanged.
- Load with rsp_ready=0 for 5 cycles →
  - rsp_valid and rsp_rdata stable, req_ready=0, a new req_valid is ignored;
  - raise rsp_ready → one handshake, then IDLE.
- Assert rst=0 during WAIT of a store to 0x20 (be=4'hF, wdata=0x0000AAAA, prior content 0) → rsp_valid never rises; a later load of 0x20 returns 0.
- DMEM_ALIGN_CHK_EN defined: store to 0x13 → rsp_err=1 and memory unchanged. Undefined: store to 0x13 writes word 4 (0x10).

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between the datapath (master) and the data-memory
// responder (slave): one request in flight, one response per request.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        req_re;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_re, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_re, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store against a word array,
// answered after RD_LAT+1 edges. Define DMEM_ALIGN_CHK_EN to flag misaligned addresses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
`ifdef DMEM_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     wdata_reg;
  logic [3:0]      be_reg;
  logic            we_reg;
  logic            re_reg;
  logic            req_ready_reg;
  logic            rsp_valid_reg;
  logic [31:0]     rsp_rdata_reg;
  logic            rsp_err_reg;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic            out_of_range;
  logic            misaligned;
  logic            err;
  logic            commit;
  logic [31:0]     rd_word;
  logic [31:0]     merged_word;

  assign idx          = addr_reg[AW+1:2];
  assign out_of_range = |addr_reg[31:AW+2];
  assign misaligned   = |addr_reg[1:0];
  assign err          = out_of_range | (ALIGN_CHK & misaligned);
  assign commit       = (state_reg == WAIT) && (cnt_reg == '0);
  assign rd_word      = mem[idx];

  // Write-first view of the word, so a combined store+load returns merged bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = (we_reg && be_reg[gi]) ? wdata_reg[8*gi +: 8]
                                                            : rd_word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (commit && we_reg && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_reg[b]) mem[idx][8*b +: 8] <= wdata_reg[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      we_reg        <= 1'b0;
      re_reg        <= 1'b0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            addr_reg      <= bus.req_addr;
            wdata_reg     <= bus.req_wdata;
            be_reg        <= bus.req_be;
            we_reg        <= bus.req_we;
            re_reg        <= bus.req_re;
            cnt_reg       <= CW'(RD_LAT - 1);
            req_ready_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            rsp_err_reg   <= err;
            rsp_rdata_reg <= (re_reg && !err) ? merged_word : 32'h0;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        RESP: begin
          // Response data is loaded at the commit edge; valid follows one edge later.
          if (!rsp_valid_reg) begin
            rsp_valid_reg <= 1'b1;
          end else if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, RD_LAT=2) with immediate assertions.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(256), .RD_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_we    = 1'b0;
    bus.req_re    = 1'b0;
    bus.req_be    = '0;
  endtask

  // Issue one request with rsp_ready high and check latency, data, error and return to idle.
  task automatic transact(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic re, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_we    = we;
    bus.req_re    = re;
    bus.req_be    = be;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 drive_idle();
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1 n++;
      if (bus.rsp_valid) break;
    end
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    @(posedge clk);
    #1 check({tag, "_done"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    $display("txn %s addr=%h wdata=%h we=%0d re=%0d be=%h -> rdata=%h err=%0d lat=%0d",
             tag, addr, wdata, we, re, be, exp_rdata, exp_err, n);
  endtask

  initial begin
    int n;
    drive_idle();
    bus.rsp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("idle_no_rsp", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);

    // Known initial contents for words used later
    transact("init_w0", 32'h0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
    transact("init_w8", 32'h20, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);

    transact("st_full", 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
    transact("ld_full", 32'h10, 32'h0, 1'b0, 1'b1, 4'h0, 32'hDEADBEEF, 1'b0);
    transact("st_part", 32'h10, 32'h11223344, 1'b1, 1'b0, 4'b0101, 32'h0, 1'b0);
    transact("ld_part", 32'h10, 32'h0, 1'b0, 1'b1, 4'h0, 32'hDE22BE44, 1'b0);
    transact("ld_oor", 32'h400, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b1);
    transact("st_oor", 32'h8000_0000, 32'hFFFFFFFF, 1'b1, 1'b0, 4'hF, 32'h0, 1'b1);
    transact("ld_w0", 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
    transact("st_be0", 32'h10, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
    transact("rmw", 32'h10, 32'hAA000000, 1'b1, 1'b1, 4'b1000, 32'hAA22BE44, 1'b0);
    transact("nop", 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);

    // Backpressure: response held, new requests ignored
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_re    = 1'b1;
    @(posedge clk);
    #1 drive_idle();
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1 n++;
      if (bus.rsp_valid) break;
    end
    check("stall_latency", 32'(n), 32'd3);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rdata", bus.rsp_rdata, 32'hAA22BE44);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    drive_idle();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 check("stall_release", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    $display("txn stall addr=00000010 held 5 cycles -> rdata=aa22be44");
    transact("ld_after_stall", 32'h10, 32'h0, 1'b0, 1'b1, 4'h0, 32'hAA22BE44, 1'b0);

    // Reset during WAIT of a store: nothing written, no response
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h0000AAAA;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    @(posedge clk);
    #1 drive_idle();
    rst = 1'b0;
    #1 check("rst_wait_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("rst_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    $display("txn rst_wait addr=00000020 store dropped");
    transact("ld_w8", 32'h20, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);

    // Misaligned store
`ifdef DMEM_ALIGN_CHK_EN
    transact("st_mis", 32'h13, 32'h12345678, 1'b1, 1'b0, 4'hF, 32'h0, 1'b1);
    transact("ld_mis", 32'h10, 32'h0, 1'b0, 1'b1, 4'h0, 32'hAA22BE44, 1'b0);
`else
    transact("st_mis", 32'h13, 32'h12345678, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0);
    transact("ld_mis", 32'h10, 32'h0, 1'b0, 1'b1, 4'h0, 32'h12345678, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
